// File: rtl/data_mem_io_pkg.sv
// rtl/data_mem_io_pkg.sv - shared offsets, status bit positions and defaults for data_mem_io
package data_mem_io_pkg;

  typedef enum logic [1:0] {
    OFF_GPIO   = 2'd0,
    OFF_CYCLE  = 2'd1,
    OFF_TXDATA = 2'd2,
    OFF_TXSTAT = 2'd3
  } io_off_e;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 5;

  localparam logic [31:0] DEFAULT_IO_BASE = 32'hFFFF_0000;

endpackage

// File: rtl/data_mem_io_tx_fifo.sv
// rtl/data_mem_io_tx_fifo.sv - registered-head FIFO; a push while full only lands if a pop frees a slot
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push_eff;
  logic             w_pop_eff;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_dout     = o_empty ? '0 : r_mem[r_rd];
  assign w_pop_eff  = i_pop && !o_empty;
  assign w_push_eff = i_push && (!o_full || w_pop_eff);

  always_ff @(posedge clk) begin
    if (w_push_eff) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_eff) r_wr <= r_wr + PW'(1);
      if (w_pop_eff)  r_rd <= r_rd + PW'(1);
      case ({w_push_eff, w_pop_eff})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_io.sv
// rtl/data_mem_io.sv - data-memory responder: word RAM plus GPIO, cycle counter and TX FIFO I/O
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] IO_BASE   = DEFAULT_IO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_gpio;
  logic [31:0]   r_cycle;
  logic          r_ovf;

  logic          w_ram_hit;
  logic          w_io_hit;
  logic [AW-1:0] w_ram_idx;
  io_off_e       w_off;
  logic          w_io_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_txstat;

  assign w_ram_hit = (Addr < RAM_BYTES);
  assign w_io_hit  = (Addr[31:4] == IO_BASE[31:4]);
  assign w_ram_idx = Addr[AW+1:2];
  assign w_off     = io_off_e'(Addr[3:2]);
  assign w_io_wr   = MemWrite && w_io_hit;
  assign w_push    = w_io_wr && (w_off == OFF_TXDATA);
  assign w_pop     = tx_valid && tx_ready;
  assign tx_valid  = !w_empty;
  assign gpio_out  = r_gpio;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (WriteData[7:0]),
    .i_pop   (w_pop),
    .o_dout  (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_txstat                            = '0;
    w_txstat[STAT_FULL_BIT]             = w_full;
    w_txstat[STAT_EMPTY_BIT]            = w_empty;
    w_txstat[STAT_OVF_BIT]              = r_ovf;
    w_txstat[STAT_COUNT_LSB +: CW]      = w_count;
  end

  // Loads see pre-edge state, so a same-cycle store never shows through.
  always_comb begin
    ReadData = '0;
    if (w_ram_hit) begin
      ReadData = r_ram[w_ram_idx];
    end else if (w_io_hit) begin
      case (w_off)
        OFF_GPIO:   ReadData = r_gpio;
        OFF_CYCLE:  ReadData = r_cycle;
        OFF_TXSTAT: ReadData = w_txstat;
        default:    ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit) r_ram[w_ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpio  <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_io_wr && (w_off == OFF_GPIO)) r_gpio <= WriteData;

      if (w_io_wr && (w_off == OFF_CYCLE)) r_cycle <= '0;
      else                                 r_cycle <= r_cycle + 32'd1;

      // A dropped push outranks a same-cycle status clear.
      if (w_push && w_full && !w_pop)            r_ovf <= 1'b1;
      else if (w_io_wr && (w_off == OFF_TXSTAT)) r_ovf <= 1'b0;
    end
  end

endmodule
